nbody_snapshot_reader: RTL and testbench

// - Bus master that sits directly downstream of the nbody accelerator's 64-bit register port.
// - After each simulation step it polls DONE, freezes the state (READ=1), reads X then Y for bodies 0..N-1,

---
 rtl/nbody_snapshot_reader.sv | 183 ++++++++++++++++++
 tb/tb_nbody_snapshot_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_snapshot_reader.sv
// Bus master that snapshots all nbody positions after each step and streams {idx,x,y} beats.
// Optional DONE-poll timeout compiled in with `define NBODY_SNAP_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_POLL    | issue DONE read
// S_WAIT_P  | wait RD_LAT for DONE data
// S_GAP     | POLL_GAP idle cycles before next poll
// S_FREEZE  | write READ=1
// S_RDX     | issue READ_X read for idx
// S_WAIT_X  | wait RD_LAT, capture x
// S_RDY     | issue READ_Y read for idx
// S_WAIT_Y  | wait RD_LAT, capture y
// S_PUSH    | present beat until out_ready
// S_RELEASE | write READ=0, pulse frame_done
module nbody_snapshot_reader #(
  parameter int ADDR_W   = 16,
  parameter int IDX_W    = 9,
  parameter int RD_LAT   = 2,
  parameter int POLL_GAP = 8
`ifdef NBODY_SNAP_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    n_bodies,
  output logic              busy,
  output logic              frame_done,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_read,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_writedata,
  input  logic [63:0]       m_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [63:0]       out_x,
  output logic [63:0]       out_y,
  output logic              out_last,
  output logic              err
);

  localparam logic [6:0] SEL_DONE   = 7'h40;
  localparam logic [6:0] SEL_READ   = 7'h01;
  localparam logic [6:0] SEL_READ_X = 7'h41;
  localparam logic [6:0] SEL_READ_Y = 7'h42;
  localparam logic [IDX_W:0] N_MAX  = (IDX_W+1)'(1 << IDX_W);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_WAIT_P, S_GAP, S_FREEZE, S_RDX,
    S_WAIT_X, S_RDY, S_WAIT_Y, S_PUSH, S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   n_q;
  logic [IDX_W:0]   idx_nxt;
  logic [63:0]      x_q, y_q;
  logic [6:0]       sel;
  logic             use_idx;
  logic             cnt_zero;
  logic             timeout_hit;

  assign cnt_zero = (cnt_q == 16'd0);
  assign idx_nxt  = (IDX_W+1)'(idx_q) + (IDX_W+1)'(1);

`ifdef NBODY_SNAP_TIMEOUT_EN
  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [PW-1:0] poll_q;
  logic          err_q;

  // Hit on the TIMEOUT-th consecutive failed DONE read of this snapshot.
  assign timeout_hit = (poll_q == PW'(TIMEOUT - 1));
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      poll_q <= '0;
    end else if (state_q == S_WAIT_P && cnt_zero && !m_readdata[0]) begin
      poll_q <= poll_q + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_writedata = 64'd0;
    sel         = 7'd0;
    use_idx     = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_POLL;
      S_POLL: begin
        m_read  = 1'b1;
        sel     = SEL_DONE;
        state_d = S_WAIT_P;
      end
      S_WAIT_P: if (cnt_zero) begin
        if (m_readdata[0])    state_d = S_FREEZE;
        else if (timeout_hit) state_d = S_IDLE;
        else                  state_d = S_GAP;
      end
      S_GAP:    if (cnt_zero) state_d = S_POLL;
      S_FREEZE: begin
        m_write     = 1'b1;
        sel         = SEL_READ;
        m_writedata = 64'd1;
        state_d     = (n_q != '0) ? S_RDX : S_RELEASE;
      end
      S_RDX: begin
        m_read  = 1'b1;
        sel     = SEL_READ_X;
        use_idx = 1'b1;
        state_d = S_WAIT_X;
      end
      S_WAIT_X: if (cnt_zero) state_d = S_RDY;
      S_RDY: begin
        m_read  = 1'b1;
        sel     = SEL_READ_Y;
        use_idx = 1'b1;
        state_d = S_WAIT_Y;
      end
      S_WAIT_Y: if (cnt_zero) state_d = S_PUSH;
      S_PUSH:   if (out_ready) state_d = (idx_nxt < n_q) ? S_RDX : S_RELEASE;
      S_RELEASE: begin
        m_write    = 1'b1;
        sel        = SEL_READ;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign m_chipselect = m_read | m_write;
  assign m_addr       = {sel, (use_idx ? idx_q : {IDX_W{1'b0}})};
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = (state_q == S_PUSH);
  assign out_idx      = idx_q;
  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_last     = out_valid && (idx_nxt == n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      n_q     <= '0;
      x_q     <= 64'd0;
      y_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      // Shared down-counter: read latency after each read, poll gap after a failed DONE.
      case (state_q)
        S_POLL, S_RDX, S_RDY: cnt_q <= 16'(RD_LAT - 1);
        S_WAIT_P: cnt_q <= cnt_zero ? 16'(POLL_GAP - 1) : cnt_q - 16'd1;
        default:  if (!cnt_zero) cnt_q <= cnt_q - 16'd1;
      endcase
      if (state_q == S_IDLE && start) begin
        idx_q <= '0;
        n_q   <= (n_bodies > N_MAX) ? N_MAX : n_bodies;
      end
      if (state_q == S_WAIT_X && cnt_zero) x_q <= m_readdata;
      if (state_q == S_WAIT_Y && cnt_zero) y_q <= m_readdata;
      if (state_q == S_PUSH && out_ready) idx_q <= idx_nxt[IDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_nbody_snapshot_reader.sv
// Scoreboard bench for nbody_snapshot_reader: a behavioural nbody bus model answers reads,
// expected beats/writes are queued at start and popped by monitors.
module tb_nbody_snapshot_reader;
  localparam int RD_LAT       = 2;
  localparam int POLL_GAP     = 8;
  localparam int IDX_W        = 9;
  localparam int ADDR_W       = 16;
  localparam int BEAT_GAP     = 2 * (RD_LAT + 1) + 1;
  localparam int POLL_SPACING = POLL_GAP + RD_LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W:0]    n_bodies = '0;
  logic              busy, frame_done, m_chipselect, m_write, m_read;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_writedata;
  logic [63:0]       m_readdata = 64'd0;
  logic              out_valid, out_last, err;
  logic              out_ready = 1'b1;
  logic [IDX_W-1:0]  out_idx;
  logic [63:0]       out_x, out_y;

  nbody_snapshot_reader #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .RD_LAT(RD_LAT), .POLL_GAP(POLL_GAP)
`ifdef NBODY_SNAP_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_bodies(n_bodies), .busy(busy),
    .frame_done(frame_done), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_read(m_read), .m_addr(m_addr), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_x(out_x), .out_y(out_y), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  idx;
    logic [63:0] x;
    logic [63:0] y;
    logic        last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [63:0] exp_wr[$];
  logic [63:0] x_mem[0:511];
  logic [63:0] y_mem[0:511];

  int errors = 0, checks = 0;
  int cyc = 0, poll_seen = 0, done_after = 0, last_poll = 0, fd_cnt = 0;
  int rd_wait = 0, ready_mode = 0, beats_done = 0, stall_cnt = 0, last_beat = 0;
  logic [63:0] rd_pend = 64'd0;
  bit          hold = 1'b0;
  logic [8:0]  h_idx;
  logic [63:0] h_x, h_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // nbody register-port model plus write scoreboard.
  always @(negedge clk) begin
    logic [63:0] w;
    if (!rst_n) begin
      rd_wait    = 0;
      m_readdata = 64'd0;
    end else begin
      if (rd_wait > 0) begin
        rd_wait--;
        m_readdata = (rd_wait == 0) ? rd_pend : {$urandom(), $urandom()};
      end else begin
        m_readdata = {$urandom(), $urandom()};
      end
      if (m_chipselect | m_read | m_write)
        chk("bus_strobes", {61'd0, m_chipselect, m_read ^ m_write, ~(m_read & m_write)}, 64'd7);
      if (m_chipselect && m_read) begin
        chk("one_outstanding", rd_wait, 0);
        case (m_addr[15:9])
          7'h40: begin
            poll_seen++;
            if (poll_seen > 1) chk("poll_spacing", cyc - last_poll, POLL_SPACING);
            last_poll = cyc;
            rd_pend = (poll_seen > done_after) ? 64'd1 : ({$urandom(), $urandom()} & ~64'd1);
          end
          7'h41:   rd_pend = x_mem[m_addr[8:0]];
          7'h42:   rd_pend = y_mem[m_addr[8:0]];
          default: chk("read_sel", {57'd0, m_addr[15:9]}, 64'h41);
        endcase
        rd_wait = RD_LAT;
      end
      if (m_chipselect && m_write) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h required=none", m_writedata);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", m_addr, 64'h0200);
          chk("wr_data", m_writedata, w);
          chk("frame_done_on_release", frame_done, (w == 64'd0));
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  // Downstream ready driver and beat monitor.
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      hold      = 1'b0;
      out_ready = 1'b1;
    end else begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = !(out_valid && beats_done == 0 && stall_cnt < 20);
          if (!out_ready) stall_cnt++;
        end
      endcase
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_idx", out_idx, h_idx);
        chk("stall_x", out_x, h_x);
        chk("stall_y", out_y, h_y);
        chk("stall_no_bus", m_chipselect, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual_idx=%0d required=none", out_idx);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_idx", out_idx, b.idx);
          chk("beat_x", out_x, b.x);
          chk("beat_y", out_y, b.y);
          chk("beat_last", out_last, b.last);
        end
        if (ready_mode == 0 && beats_done > 0) chk("beat_gap", cyc - last_beat, BEAT_GAP);
        last_beat = cyc;
        beats_done++;
        hold = 1'b0;
      end else if (out_valid) begin
        hold  = 1'b1;
        h_idx = out_idx;
        h_x   = out_x;
        h_y   = out_y;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic prep(input int nn, input int polls, input int mode, input bit fill_rand);
    if (fill_rand)
      for (int i = 0; i < nn; i++) begin
        x_mem[i] = {$urandom(), $urandom()};
        y_mem[i] = {$urandom(), $urandom()};
      end
    done_after = polls;
    poll_seen  = 0;
    ready_mode = mode;
    beats_done = 0;
    stall_cnt  = 0;
    for (int i = 0; i < nn; i++)
      exp_beats.push_back('{idx: 9'(i), x: x_mem[i], y: y_mem[i], last: (i == nn - 1)});
  endtask

  task automatic pulse_start(input int n);
    n_bodies = 10'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_bodies = 10'($urandom_range(0, 1023));
    chk("busy_on_start", busy, 1);
  endtask

  task automatic run_snap(input int n, input int polls, input int mode, input bit fill_rand,
                          input bit extra);
    int nn, fd0;
    bit seen;
    nn = (n > 512) ? 512 : n;
    prep(nn, polls, mode, fill_rand);
    exp_wr.push_back(64'd1);
    exp_wr.push_back(64'd0);
    fd0 = fd_cnt;
    pulse_start(n);
    if (extra) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        if (extra) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    chk("frame_seen", seen, 1);
    repeat (extra ? 30 : 3) @(negedge clk);
    chk("busy_after", busy, 0);
    chk("frames", fd_cnt - fd0, 1);
    chk("polls", poll_seen, polls + 1);
    chk("beats_left", exp_beats.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
    exp_beats.delete();
    exp_wr.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, frame_done, m_chipselect, m_write, m_read, out_valid, out_last, err}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_x", out_x, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // DONE after 3 failed polls, three known bodies.
    x_mem[0] = $realtobits(1.0);  y_mem[0] = $realtobits(10.0);
    x_mem[1] = $realtobits(-5.0); y_mem[1] = $realtobits(-15.0);
    x_mem[2] = $realtobits(20.0); y_mem[2] = $realtobits(0.0);
    run_snap(3, 3, 0, 1'b0, 1'b0);

    // Empty frame.
    run_snap(0, 0, 0, 1'b1, 1'b0);

    // 20-cycle stall on beat 0.
    run_snap(2, 1, 2, 1'b1, 1'b0);

    // Random sizes, poll counts and backpressure.
    for (int t = 0; t < 8; t++)
      run_snap($urandom_range(1, 12), $urandom_range(0, 3), 1, 1'b1, 1'b0);

    // Oversized body count saturates to 512.
    run_snap(700, 0, 0, 1'b1, 1'b0);

    // Reset during the Y read of body 5 of 25.
    prep(25, 0, 0, 1'b1);
    exp_wr.push_back(64'd1);
    pulse_start(25);
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (m_read && m_addr[15:9] == 7'h42 && m_addr[8:0] == 9'd5) seen = 1'b1;
    end
    chk("reached_rdy5", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {busy, frame_done, m_chipselect, m_write, m_read, out_valid, out_last, err}, 0);
    chk("abort_addr", m_addr, 0);
    chk("abort_wdata", m_writedata, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_x", out_x, 0);
    chk("abort_y", out_y, 0);
    chk("abort_beats_pending", exp_beats.size(), 20);
    chk("abort_writes_pending", exp_wr.size(), 0);
    exp_beats.delete();
    exp_wr.delete();
    fd0 = fd_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_no_release", fd_cnt - fd0, 0);
    run_snap(25, 0, 0, 1'b1, 1'b0);

    // Start while busy and start coincident with frame_done are both ignored.
    run_snap(2, 1, 0, 1'b1, 1'b1);

`ifdef NBODY_SNAP_TIMEOUT_EN
    prep(0, 1 << 30, 0, 1'b0);
    fd0 = fd_cnt;
    pulse_start(3);
    for (int k = 0; k < 500 && busy; k++) @(negedge clk);
    chk("to_busy_fell", busy, 0);
    chk("to_polls", poll_seen, 4);
    chk("to_err", err, 1);
    repeat (20) @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_no_frame", fd_cnt - fd0, 0);
    chk("to_no_more_polls", poll_seen, 4);
`else
    prep(1, 1 << 30, 0, 1'b1);
    exp_wr.push_back(64'd1);
    exp_wr.push_back(64'd0);
    fd0 = fd_cnt;
    pulse_start(1);
    repeat (200) @(negedge clk);
    chk("poll_still_busy", busy, 1);
    chk("poll_no_err", err, 0);
    chk("polls_continue", (poll_seen >= 15), 1);
    done_after = poll_seen;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("late_done_frame", seen, 1);
    repeat (3) @(negedge clk);
    chk("late_done_frames", fd_cnt - fd0, 1);
    chk("late_done_beats_left", exp_beats.size(), 0);
    chk("late_done_writes_left", exp_wr.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
